// File: rtl/mux3_rr_arbiter_if.sv
// Bundle for the 3-requester, 2-bit mux arbiter: requests, per-requester data, grant and output.
// Latency: none (wires only).
// Backpressure: none; req is held by each requester until it no longer needs the mux.
//
// Ports:
//   req[2:0]   request per requester, bit i = requester i
//   d0/d1/d2   2-bit data of requesters 0/1/2
//   gnt[2:0]   registered one-hot grant, or zero
//   sel[1:0]   registered mux select, index of current/last owner
//   y[1:0]     registered selected data
//   y_valid    y holds data of a valid granted transfer
interface mux3_rr_arbiter_if;
    logic [2:0] req;
    logic [1:0] d0;
    logic [1:0] d1;
    logic [1:0] d2;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic [1:0] y;
    logic       y_valid;

    // Requester side drives requests and data and observes the arbiter result.
    modport master (
        output req, d0, d1, d2,
        input  gnt, sel, y, y_valid
    );

    // Arbiter side.
    modport slave (
        input  req, d0, d1, d2,
        output gnt, sel, y, y_valid
    );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 3-input, 2-bit mux; registers the selected data.
// Latency: req at edge N-1 -> gnt/sel at edge N -> y/y_valid at edge N+1.
// Backpressure: none; an owner keeps the grant for at most HOLD_CYCLES cycles, then it is rotated.
//
// Ports: clk (rising edge), rst_n (async active-low), bus (mux3_rr_arbiter_if.slave):
//   req/d0/d1/d2 in; gnt/sel/y/y_valid out, all registered.
// Build option: define MUX3_ARB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2 (hold limit still applies).
module mux3_rr_arbiter #(
    parameter int HOLD_CYCLES = 4,   // 1..7
    parameter int CNT_W       = 3    // must hold HOLD_CYCLES-1
) (
    input  logic              clk,
    input  logic              rst_n,
    mux3_rr_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

`ifdef MUX3_ARB_FIXED_PRIO_EN
    function automatic logic [1:0] pick(input logic [2:0] r);
        if (r[0])      pick = 2'd0;
        else if (r[1]) pick = 2'd1;
        else           pick = 2'd2;
    endfunction
`else
    // Scan starts just after the last owner, so the last owner is considered last.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] lst);
        case (lst)
            2'd0:    pick = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            2'd1:    pick = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
            default: pick = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
        endcase
    endfunction
`endif

    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [1:0]       y_q, y_d;
    logic             yv_q, yv_d;

    logic [1:0]       win;
    logic             any_req;
    logic             own_req;
    logic             release_own;
    logic [1:0]       d_sel;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            sel_q   <= 2'b00;
            last_q  <= 2'd2;        // requester 0 wins the first arbitration
            hold_q  <= '0;
            y_q     <= 2'b00;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
        end
    end

    // Next-state logic.
    always_comb begin
        any_req = |bus.req;
`ifdef MUX3_ARB_FIXED_PRIO_EN
        win = pick(bus.req);
`else
        win = pick(bus.req, last_q);
`endif
        case (sel_q)
            2'd0:    own_req = bus.req[0];
            2'd1:    own_req = bus.req[1];
            default: own_req = bus.req[2];
        endcase
        // Owner gives up the mux when it drops req or has used its full hold window.
        release_own = !own_req || (hold_q == HOLD_LAST);

        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = GRANT;
            default: if (release_own && !any_req) state_d = IDLE;
        endcase
    end

    // Grant bookkeeping and registered datapath inputs.
    always_comb begin
        gnt_d  = gnt_q;
        sel_d  = sel_q;
        last_d = last_q;
        hold_d = hold_q;

        if (state_q == IDLE) begin
            gnt_d = 3'b000;
            if (any_req) begin
                gnt_d  = 3'b001 << win;
                sel_d  = win;
                last_d = win;
                hold_d = '0;
            end
        end else if (release_own) begin
            hold_d = '0;
            if (any_req) begin
                // Handover (or regrant of a sole owner) on the same edge, no idle bubble.
                gnt_d  = 3'b001 << win;
                sel_d  = win;
                last_d = win;
            end else begin
                gnt_d = 3'b000;
            end
        end else begin
            hold_d = hold_q + CNT_W'(1);
        end

        case (sel_q)
            2'd0:    d_sel = bus.d0;
            2'd1:    d_sel = bus.d1;
            default: d_sel = bus.d2;
        endcase
        yv_d = |(gnt_q & bus.req);
        y_d  = (gnt_q != 3'b000) ? d_sel : y_q;

        bus.gnt     = gnt_q;
        bus.sel     = sel_q;
        bus.y       = y_q;
        bus.y_valid = yv_q;
    end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
module tb_mux3_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux3_rr_arbiter_if m_if ();
    mux3_rr_arbiter_if h2_if ();
    mux3_rr_arbiter_if h1_if ();

    mux3_rr_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m_if));
    mux3_rr_arbiter #(.HOLD_CYCLES(2), .CNT_W(3)) u_h2  (.clk(clk), .rst_n(rst_n), .bus(h2_if));
    mux3_rr_arbiter #(.HOLD_CYCLES(1), .CNT_W(3)) u_h1  (.clk(clk), .rst_n(rst_n), .bus(h1_if));

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [1:0] d0, d1, d2;
        logic [2:0] gnt;
        logic [1:0] sel;
        logic [1:0] y;
        logic       yv;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void add(input logic rst, input logic [2:0] req,
                                input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2,
                                input logic [2:0] gnt, input logic [1:0] sel,
                                input logic [1:0] y, input logic yv);
        vec_t v;
        v.rst = rst; v.req = req; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.gnt = gnt; v.sel = sel; v.y = y; v.yv = yv;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        m_if.req = 3'b000;  m_if.d0 = 2'b00;  m_if.d1 = 2'b00;  m_if.d2 = 2'b00;
        h2_if.req = 3'b000; h2_if.d0 = 2'b00; h2_if.d1 = 2'b00; h2_if.d2 = 2'b00;
        h1_if.req = 3'b000; h1_if.d0 = 2'b00; h1_if.d1 = 2'b00; h1_if.d2 = 2'b00;

        // Idle, then a single requester held then dropped.
        for (int i = 0; i < 5; i++) add(0, 3'b000, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0);
        add(0, 3'b010, 0, 3, 0, 3'b010, 2'd1, 2'd0, 0);
        for (int i = 0; i < 3; i++) add(0, 3'b010, 0, 3, 0, 3'b010, 2'd1, 2'd3, 1);
        add(0, 3'b000, 0, 3, 0, 3'b000, 2'd1, 2'd3, 0);
        add(0, 3'b000, 0, 3, 0, 3'b000, 2'd1, 2'd3, 0);
`ifndef MUX3_ARB_FIXED_PRIO_EN
        // All three requesting: four cycles each, y one cycle behind sel.
        add(1, 3'b111, 1, 2, 3, 3'b001, 2'd0, 2'd0, 0);
        for (int i = 0; i < 3; i++) add(0, 3'b111, 1, 2, 3, 3'b001, 2'd0, 2'd1, 1);
        add(0, 3'b111, 1, 2, 3, 3'b010, 2'd1, 2'd1, 1);
        for (int i = 0; i < 3; i++) add(0, 3'b111, 1, 2, 3, 3'b010, 2'd1, 2'd2, 1);
        add(0, 3'b111, 1, 2, 3, 3'b100, 2'd2, 2'd2, 1);
        for (int i = 0; i < 3; i++) add(0, 3'b111, 1, 2, 3, 3'b100, 2'd2, 2'd3, 1);
        add(0, 3'b111, 1, 2, 3, 3'b001, 2'd0, 2'd3, 1);
        add(0, 3'b111, 1, 2, 3, 3'b001, 2'd0, 2'd1, 1);
        // Owner 0 drops mid-hold: grant moves to 1 on that edge, y_valid low once.
        add(0, 3'b110, 1, 2, 3, 3'b010, 2'd1, 2'd1, 0);
        add(0, 3'b110, 1, 2, 3, 3'b010, 2'd1, 2'd2, 1);
`else
        // Fixed priority: 1 owns until expiry, then 0 wins and keeps being regranted.
        add(1, 3'b110, 1, 2, 3, 3'b010, 2'd1, 2'd0, 0);
        for (int i = 0; i < 3; i++) add(0, 3'b110, 1, 2, 3, 3'b010, 2'd1, 2'd2, 1);
        add(0, 3'b111, 1, 2, 3, 3'b001, 2'd0, 2'd2, 1);
        for (int i = 0; i < 7; i++) add(0, 3'b111, 1, 2, 3, 3'b001, 2'd0, 2'd1, 1);
`endif

        #12;
        chk("reset_gnt", {5'b0, m_if.gnt}, 8'h0);
        chk("reset_sel", {6'b0, m_if.sel}, 8'h0);
        chk("reset_y",   {6'b0, m_if.y},   8'h0);
        chk("reset_yv",  {7'b0, m_if.y_valid}, 8'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) do_reset();
            m_if.req = vq[i].req;
            m_if.d0  = vq[i].d0;
            m_if.d1  = vq[i].d1;
            m_if.d2  = vq[i].d2;
            tick();
            chk($sformatf("vec%0d_gnt", i), {5'b0, m_if.gnt}, {5'b0, vq[i].gnt});
            chk($sformatf("vec%0d_sel", i), {6'b0, m_if.sel}, {6'b0, vq[i].sel});
            chk($sformatf("vec%0d_y", i),   {6'b0, m_if.y},   {6'b0, vq[i].y});
            chk($sformatf("vec%0d_yv", i),  {7'b0, m_if.y_valid}, {7'b0, vq[i].yv});
        end

        // Asynchronous reset while requester 2 owns the mux.
        m_if.req = 3'b000;
        do_reset();
        m_if.req = 3'b100; m_if.d2 = 2'd3;
        tick();
        chk("own2_gnt", {5'b0, m_if.gnt}, 8'h4);
        chk("own2_sel", {6'b0, m_if.sel}, 8'h2);
        tick();
        chk("own2_y",  {6'b0, m_if.y}, 8'h3);
        chk("own2_yv", {7'b0, m_if.y_valid}, 8'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", {5'b0, m_if.gnt}, 8'h0);
        chk("arst_sel", {6'b0, m_if.sel}, 8'h0);
        chk("arst_y",   {6'b0, m_if.y},   8'h0);
        chk("arst_yv",  {7'b0, m_if.y_valid}, 8'h0);
        #1;
        rst_n = 1'b1;
        m_if.req = 3'b111;
        tick();
        chk("post_rst_gnt", {5'b0, m_if.gnt}, 8'h1);
        m_if.req = 3'b000;

        // HOLD_CYCLES=2, sole requester: regranted at every expiry, never a gap.
        h2_if.req = 3'b001; h2_if.d0 = 2'd2;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("h2_gnt%0d", k), {5'b0, h2_if.gnt}, 8'h1);
            if (k > 0) begin
                chk($sformatf("h2_yv%0d", k), {7'b0, h2_if.y_valid}, 8'h1);
                chk($sformatf("h2_y%0d", k),  {6'b0, h2_if.y}, 8'h2);
            end
        end
        h2_if.req = 3'b000;

        // HOLD_CYCLES=1 with two requesters.
        do_reset();
        h1_if.req = 3'b011; h1_if.d0 = 2'd1; h1_if.d1 = 2'd2;
        for (int k = 0; k < 6; k++) begin
            tick();
`ifndef MUX3_ARB_FIXED_PRIO_EN
            chk($sformatf("h1_gnt%0d", k), {5'b0, h1_if.gnt}, (k % 2 == 0) ? 8'h1 : 8'h2);
            if (k > 0)
                chk($sformatf("h1_y%0d", k), {6'b0, h1_if.y}, (k % 2 == 1) ? 8'h1 : 8'h2);
`else
            chk($sformatf("h1_gnt%0d", k), {5'b0, h1_if.gnt}, 8'h1);
            if (k > 0)
                chk($sformatf("h1_y%0d", k), {6'b0, h1_if.y}, 8'h1);
`endif
        end
        h1_if.req = 3'b000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
